// File: rtl/pic_multi_ch.sv
// IO interconnect and round-robin interrupt controller between the CPU IO port and P_CH device channels.
// Optional build macro: PIC_MULTI_CH_IRQ_MASK_EN adds iIRQ_MASK (1 = channel may raise interrupts).
module pic_multi_ch #(
  parameter int          P_CH         = 4,
  parameter logic [31:0] P_BASE_ADDR  = 32'h200,
  parameter int          P_WIN_LOG2   = 9,
  parameter int          P_IRQ_STRIDE = 4
) (
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              iIO_REQ,
  output logic              oIO_BUSY,
  input  logic [1:0]        iIO_ORDER,
  input  logic              iIO_RW,
  input  logic [31:0]       iIO_ADDR,
  input  logic [31:0]       iIO_DATA,
  output logic              oIO_VALID,
  input  logic              iIO_BUSY,
  output logic [31:0]       oIO_DATA,
  output logic              oIO_ERROR,
  output logic              oIO_INTERRUPT_VALID,
  output logic [5:0]        oIO_INTERRUPT_NUM,
  input  logic              iIO_INTERRUPT_ACK,
  output logic [P_CH-1:0]   oDEV_REQ,
  input  logic [P_CH-1:0]   iDEV_BUSY,
  output logic              oDEV_RW,
  output logic [31:0]       oDEV_ADDR,
  output logic [31:0]       oDEV_DATA,
  input  logic [P_CH-1:0]   iDEV_REQ,
  output logic [P_CH-1:0]   oDEV_BUSY,
  input  logic [P_CH*32-1:0] iDEV_DATA,
  input  logic [P_CH-1:0]   iDEV_IRQ_REQ,
  input  logic [P_CH*6-1:0] iDEV_IRQ_NUM,
`ifdef PIC_MULTI_CH_IRQ_MASK_EN
  input  logic [P_CH-1:0]   iIRQ_MASK,
`endif
  output logic [P_CH-1:0]   oDEV_IRQ_ACK
);

  localparam int CW = (P_CH > 1) ? $clog2(P_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RDWAIT, S_RESP} req_state_t;
  typedef enum logic {IRQ_IDLE, IRQ_WAIT} irq_state_t;

  req_state_t      r_state;
  irq_state_t      r_irq_state;
  logic [CW-1:0]   r_ch;
  logic            r_rw;
  logic [31:0]     r_off;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_err_flag;
  logic            r_err_pulse;
  logic [CW-1:0]   r_rr;
  logic [CW-1:0]   r_irq_win;
  logic [5:0]      r_irq_num;

  logic [31:0]     w_off;
  logic [31:0]     w_chsel;
  logic [31:0]     w_win_off;
  logic            w_unmapped;
  logic [P_CH-1:0] w_owner;
  logic [P_CH-1:0] w_elig;
  logic            w_found;
  logic [CW-1:0]   w_win;
  logic [5:0]      w_num;
  int              w_idx;

  assign w_off      = iIO_ADDR - P_BASE_ADDR;
  assign w_chsel    = w_off >> P_WIN_LOG2;
  assign w_win_off  = w_off & ((32'd1 << P_WIN_LOG2) - 32'd1);
  assign w_unmapped = (iIO_ADDR < P_BASE_ADDR) || (w_chsel >= 32'(P_CH));
  assign w_owner    = P_CH'(1) << r_ch;

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_state     <= S_IDLE;
      r_ch        <= '0;
      r_rw        <= 1'b0;
      r_off       <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_err_flag  <= 1'b0;
      r_err_pulse <= 1'b0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (iIO_REQ) begin
            if (iIO_RW && (iIO_ORDER != 2'h2 || w_unmapped)) begin
              r_err_pulse <= 1'b1;
            end else if (w_unmapped) begin
              r_rdata    <= '0;
              r_err_flag <= 1'b1;
              r_state    <= S_RESP;
            end else begin
              r_ch       <= w_chsel[CW-1:0];
              r_rw       <= iIO_RW;
              r_off      <= w_win_off;
              r_wdata    <= iIO_DATA;
              r_err_flag <= 1'b0;
              r_state    <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!iDEV_BUSY[r_ch]) r_state <= r_rw ? S_IDLE : S_RDWAIT;
        end
        S_RDWAIT: begin
          // Only the owning channel's return is accepted; others stay backpressured.
          if (iDEV_REQ[r_ch]) begin
            r_rdata <= iDEV_DATA[32*int'(r_ch) +: 32];
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (!iIO_BUSY) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign oIO_BUSY  = (r_state != S_IDLE);
  assign oIO_VALID = (r_state == S_RESP);
  assign oIO_DATA  = (r_state == S_RESP) ? r_rdata : '0;
  assign oIO_ERROR = r_err_pulse | ((r_state == S_RESP) & r_err_flag);
  assign oDEV_REQ  = (r_state == S_ISSUE && !iDEV_BUSY[r_ch]) ? w_owner : '0;
  assign oDEV_BUSY = (r_state == S_RDWAIT) ? ~w_owner : '1;
  assign oDEV_RW   = r_rw;
  assign oDEV_ADDR = r_off;
  assign oDEV_DATA = r_wdata;

`ifdef PIC_MULTI_CH_IRQ_MASK_EN
  assign w_elig = iDEV_IRQ_REQ & iIRQ_MASK;
`else
  assign w_elig = iDEV_IRQ_REQ;
`endif

  // Search starts one past the last winner so every requester is served in turn.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_num   = '0;
    w_idx   = 0;
    for (int i = 1; i <= P_CH; i++) begin
      w_idx = (int'(r_rr) + i) % P_CH;
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = CW'(w_idx);
        w_num   = iDEV_IRQ_NUM[6*w_idx +: 6] + 6'((w_idx * P_IRQ_STRIDE) % 64);
      end
    end
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      r_irq_state <= IRQ_IDLE;
      r_rr        <= CW'(P_CH - 1);
      r_irq_win   <= '0;
      r_irq_num   <= '0;
    end else begin
      case (r_irq_state)
        IRQ_IDLE: begin
          if (w_found) begin
            r_irq_win   <= w_win;
            r_irq_num   <= w_num;
            r_irq_state <= IRQ_WAIT;
          end
        end
        IRQ_WAIT: begin
          if (iIO_INTERRUPT_ACK) begin
            r_rr        <= r_irq_win;
            r_irq_state <= IRQ_IDLE;
          end
        end
        default: r_irq_state <= IRQ_IDLE;
      endcase
    end
  end

  assign oIO_INTERRUPT_VALID = (r_irq_state == IRQ_WAIT);
  assign oIO_INTERRUPT_NUM   = (r_irq_state == IRQ_WAIT) ? r_irq_num : '0;
  assign oDEV_IRQ_ACK        = (r_irq_state == IRQ_WAIT && iIO_INTERRUPT_ACK) ?
                               (P_CH'(1) << r_irq_win) : '0;

endmodule

// File: tb/tb_pic_multi_ch.sv
// Self-checking bench for pic_multi_ch (P_CH=4): directed spec scenarios plus randomized traffic
// against a transaction-level model; optional PIC_MULTI_CH_IRQ_MASK_EN build adds mask scenarios.
module tb_pic_multi_ch;
  logic         iCLOCK = 1'b0;
  logic         inRESET;
  logic         iIO_REQ, iIO_RW, iIO_BUSY, iIO_INTERRUPT_ACK;
  logic [1:0]   iIO_ORDER;
  logic [31:0]  iIO_ADDR, iIO_DATA;
  logic [3:0]   iDEV_BUSY, iDEV_REQ, iDEV_IRQ_REQ;
  logic [127:0] iDEV_DATA;
  logic [23:0]  iDEV_IRQ_NUM;
  logic [3:0]   mask_v;
  logic         oIO_BUSY, oIO_VALID, oIO_ERROR, oIO_INTERRUPT_VALID, oDEV_RW;
  logic [31:0]  oIO_DATA, oDEV_ADDR, oDEV_DATA;
  logic [5:0]   oIO_INTERRUPT_NUM;
  logic [3:0]   oDEV_REQ, oDEV_BUSY, oDEV_IRQ_ACK;

  pic_multi_ch #(.P_CH(4), .P_BASE_ADDR(32'h200), .P_WIN_LOG2(9), .P_IRQ_STRIDE(4)) dut (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .iIO_REQ(iIO_REQ), .oIO_BUSY(oIO_BUSY),
    .iIO_ORDER(iIO_ORDER), .iIO_RW(iIO_RW), .iIO_ADDR(iIO_ADDR), .iIO_DATA(iIO_DATA),
    .oIO_VALID(oIO_VALID), .iIO_BUSY(iIO_BUSY), .oIO_DATA(oIO_DATA), .oIO_ERROR(oIO_ERROR),
    .oIO_INTERRUPT_VALID(oIO_INTERRUPT_VALID), .oIO_INTERRUPT_NUM(oIO_INTERRUPT_NUM),
    .iIO_INTERRUPT_ACK(iIO_INTERRUPT_ACK), .oDEV_REQ(oDEV_REQ), .iDEV_BUSY(iDEV_BUSY),
    .oDEV_RW(oDEV_RW), .oDEV_ADDR(oDEV_ADDR), .oDEV_DATA(oDEV_DATA), .iDEV_REQ(iDEV_REQ),
    .oDEV_BUSY(oDEV_BUSY), .iDEV_DATA(iDEV_DATA), .iDEV_IRQ_REQ(iDEV_IRQ_REQ),
    .iDEV_IRQ_NUM(iDEV_IRQ_NUM),
`ifdef PIC_MULTI_CH_IRQ_MASK_EN
    .iIRQ_MASK(mask_v),
`endif
    .oDEV_IRQ_ACK(oDEV_IRQ_ACK)
  );

  always #5 iCLOCK = ~iCLOCK;

  int n_chk = 0, n_err = 0, cyc_n = 0;
  always @(posedge iCLOCK) cyc_n++;

  // expected outputs for the current cycle
  logic        exp_io_busy, exp_io_valid, exp_io_error, exp_dev_chk, exp_dev_rw, exp_int_valid;
  logic [31:0] exp_io_data, exp_dev_addr, exp_dev_data;
  logic [3:0]  exp_dev_req, exp_dev_busy, exp_irq_ack;
  logic [5:0]  exp_int_num;
  bit          chk_en = 0, irq_auto = 0;

  // interrupt model: pending flag, latched winner/number, last served channel
  bit          m_pend;
  int          m_win, m_rr;
  logic [5:0]  m_num;

  // observations used by the literal checks
  int          obs_req_cnt = 0, obs_req_cyc = 0, obs_valid_cnt = 0, obs_valid_first = 0, obs_err_cnt = 0;
  logic [3:0]  obs_dev_req, obs_dev_busy;
  logic [31:0] obs_dev_addr, obs_io_data;
  logic        obs_io_err, prev_valid = 0;
  logic [3:0]  q_ack[$];
  logic [5:0]  q_num[$];
  int          t_req;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge iCLOCK) if (chk_en) begin
    chk("io_busy", 64'(oIO_BUSY), 64'(exp_io_busy));
    chk("dev_req", 64'(oDEV_REQ), 64'(exp_dev_req));
    chk("dev_busy", 64'(oDEV_BUSY), 64'(exp_dev_busy));
    chk("io_valid", 64'(oIO_VALID), 64'(exp_io_valid));
    chk("io_error", 64'(oIO_ERROR), 64'(exp_io_error));
    if (exp_io_valid) chk("io_data", 64'(oIO_DATA), 64'(exp_io_data));
    if (exp_dev_chk) begin
      chk("dev_addr", 64'(oDEV_ADDR), 64'(exp_dev_addr));
      chk("dev_rw", 64'(oDEV_RW), 64'(exp_dev_rw));
      chk("dev_data", 64'(oDEV_DATA), 64'(exp_dev_data));
    end
    chk("int_valid", 64'(oIO_INTERRUPT_VALID), 64'(exp_int_valid));
    if (exp_int_valid) chk("int_num", 64'(oIO_INTERRUPT_NUM), 64'(exp_int_num));
    chk("irq_ack", 64'(oDEV_IRQ_ACK), 64'(exp_irq_ack));
    if (oDEV_REQ != 0) begin
      obs_req_cnt++; obs_req_cyc = cyc_n; obs_dev_req = oDEV_REQ; obs_dev_addr = oDEV_ADDR;
    end
    if (oDEV_BUSY != 4'hF) obs_dev_busy = oDEV_BUSY;
    if (oIO_VALID) begin
      obs_valid_cnt++; obs_io_data = oIO_DATA; obs_io_err = oIO_ERROR;
      if (!prev_valid) obs_valid_first = cyc_n;
    end else if (oIO_ERROR) obs_err_cnt++;
    prev_valid = oIO_VALID;
    if (oDEV_IRQ_ACK != 0) begin
      q_ack.push_back(oDEV_IRQ_ACK); q_num.push_back(oIO_INTERRUPT_NUM);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  task automatic exp_idle();
    exp_io_busy = 0; exp_io_valid = 0; exp_io_error = 0; exp_io_data = 0;
    exp_dev_req = 0; exp_dev_busy = 4'hF; exp_dev_chk = 0;
    exp_dev_addr = 0; exp_dev_rw = 0; exp_dev_data = 0;
  endtask

  task automatic irq_reset_model();
    m_pend = 0; m_win = 0; m_rr = 3; m_num = 0;
  endtask

  // one clock cycle: publish interrupt expectations, advance the model with the sampled inputs
  task automatic cyc();
    logic [3:0] elig;
    exp_int_valid = m_pend;
    exp_int_num   = m_pend ? m_num : 6'd0;
    exp_irq_ack   = (m_pend && iIO_INTERRUPT_ACK) ? 4'(1 << m_win) : 4'd0;
    @(posedge iCLOCK);
    if (!inRESET) irq_reset_model();
    else if (m_pend) begin
      if (iIO_INTERRUPT_ACK) begin m_rr = m_win; m_pend = 0; end
    end else begin
      elig = iDEV_IRQ_REQ & mask_v;
      for (int i = 1; i <= 4; i++) begin
        int k;
        k = (m_rr + i) % 4;
        if (!m_pend && elig[k]) begin
          m_pend = 1; m_win = k;
          m_num = 6'((int'((iDEV_IRQ_NUM >> (6*k)) & 24'h3F) + k*4) % 64);
        end
      end
    end
    #1;
    if (irq_auto) begin
      iDEV_IRQ_REQ = 4'($urandom); iDEV_IRQ_NUM = 24'($urandom);
      iIO_INTERRUPT_ACK = ($urandom % 3 == 0);
`ifdef PIC_MULTI_CH_IRQ_MASK_EN
      mask_v = 4'($urandom);
`endif
    end
  endtask

  task automatic do_reset();
    inRESET = 0; iIO_REQ = 0; iIO_BUSY = 0; iIO_INTERRUPT_ACK = 0; iDEV_BUSY = 0; iDEV_REQ = 0;
    iDEV_IRQ_REQ = 0; iDEV_IRQ_NUM = 0; mask_v = 4'hF;
    irq_reset_model(); exp_idle();
    #1;
    chk("rst_dev_addr", 64'(oDEV_ADDR), 64'd0);
    chk("rst_dev_data", 64'(oDEV_DATA), 64'd0);
    chk("rst_dev_rw", 64'(oDEV_RW), 64'd0);
    chk("rst_io_data", 64'(oIO_DATA), 64'd0);
    chk("rst_int_num", 64'(oIO_INTERRUPT_NUM), 64'd0);
    cyc(); cyc();
    inRESET = 1;
  endtask

  task automatic resp(input logic [31:0] d, input logic e, input int niob);
    for (int k = 0; k <= niob; k++) begin
      iIO_BUSY = (k < niob);
      exp_idle(); exp_io_busy = 1; exp_io_valid = 1; exp_io_data = d; exp_io_error = e;
      cyc();
    end
    iIO_BUSY = 0; exp_idle();
  endtask

  task automatic do_req(input logic rw, input logic [1:0] order, input logic [31:0] addr,
                        input logic [31:0] wdata, input int nbusy, input int ndly,
                        input logic [31:0] rdata, input int niob, input bit rogue);
    logic [31:0] off;
    int ch;
    bit unm;
    off = addr - 32'h200;
    unm = (addr < 32'h200) || ((off >> 9) >= 32'd4);
    ch  = unm ? 0 : int'(off >> 9);
    iIO_REQ = 1; iIO_RW = rw; iIO_ORDER = order; iIO_ADDR = addr; iIO_DATA = wdata;
    t_req = cyc_n; exp_idle(); cyc();
    iIO_REQ = 0; iIO_ADDR = $urandom; iIO_DATA = $urandom; iIO_RW = 1'($urandom);
    if (rw && (order != 2'h2 || unm)) begin
      exp_idle(); exp_io_error = 1; cyc(); exp_idle(); return;
    end
    if (unm) begin resp(32'd0, 1'b1, niob); return; end
    for (int b = 0; b <= nbusy; b++) begin
      iDEV_BUSY = 4'($urandom); iDEV_BUSY[ch] = (b < nbusy);
      exp_idle(); exp_io_busy = 1; exp_dev_chk = 1;
      exp_dev_addr = off & 32'h1FF; exp_dev_rw = rw; exp_dev_data = wdata;
      exp_dev_req = (b == nbusy) ? 4'(1 << ch) : 4'd0;
      cyc();
    end
    iDEV_BUSY = 0; exp_idle();
    if (rw) return;
    for (int d = 0; d <= ndly; d++) begin
      iDEV_REQ = rogue ? 4'($urandom) : 4'd0; iDEV_REQ[ch] = (d == ndly);
      iDEV_DATA = {$urandom, $urandom, $urandom, $urandom};
      if (d == ndly) iDEV_DATA[32*ch +: 32] = rdata;
      exp_idle(); exp_io_busy = 1; exp_dev_busy = ~4'(1 << ch);
      cyc();
    end
    iDEV_REQ = 0;
    resp(rdata, 1'b0, niob);
  endtask

  task automatic irq_rounds(input int n);
    for (int r = 0; r < n; r++) begin
      iIO_INTERRUPT_ACK = 0; cyc(); cyc();
      iIO_INTERRUPT_ACK = 1; cyc();
    end
    iIO_INTERRUPT_ACK = 0;
  endtask

  initial begin
    int c0, c1, e0, v0, qa;
    logic [31:0] a;
    logic [31:0] bnd [4];
    iIO_ORDER = 2; iIO_RW = 0; iIO_ADDR = 0; iIO_DATA = 0; iDEV_DATA = 0;
    exp_idle(); exp_int_valid = 0; exp_int_num = 0; exp_irq_ack = 0;
    @(posedge iCLOCK); #1;
    chk_en = 1;
    do_reset();

    // round-robin with 1011 requesting, all local numbers 1
    iDEV_IRQ_REQ = 4'b1011; iDEV_IRQ_NUM = {4{6'd1}};
    q_ack.delete(); q_num.delete();
    irq_rounds(4);
    chk("rr_count", 64'(q_ack.size()), 64'd4);
    if (q_ack.size() == 4) begin
      chk("rr_w0", 64'(q_ack[0]), 64'h1); chk("rr_n0", 64'(q_num[0]), 64'd1);
      chk("rr_w1", 64'(q_ack[1]), 64'h2); chk("rr_n1", 64'(q_num[1]), 64'd5);
      chk("rr_w2", 64'(q_ack[2]), 64'h8); chk("rr_n2", 64'(q_num[2]), 64'd13);
      chk("rr_w3", 64'(q_ack[3]), 64'h1); chk("rr_n3", 64'(q_num[3]), 64'd1);
    end
`ifdef PIC_MULTI_CH_IRQ_MASK_EN
    do_reset();
    mask_v = 4'b1101; iDEV_IRQ_REQ = 4'b1011; iDEV_IRQ_NUM = {4{6'd1}};
    q_ack.delete(); q_num.delete();
    irq_rounds(3);
    chk("mask_count", 64'(q_ack.size()), 64'd3);
    if (q_ack.size() == 3) begin
      chk("mask_w0", 64'(q_ack[0]), 64'h1); chk("mask_w1", 64'(q_ack[1]), 64'h8);
      chk("mask_w2", 64'(q_ack[2]), 64'h1); chk("mask_n1", 64'(q_num[1]), 64'd13);
    end
    mask_v = 4'hF;
`endif
    do_reset();

    // mapped read latency and routing
    do_req(0, 2'h2, 32'h608, 32'h0, 0, 0, 32'hDEADBEEF, 0, 0);
    chk("rd_dev_req", 64'(obs_dev_req), 64'h4);
    chk("rd_dev_addr", 64'(obs_dev_addr), 64'h8);
    chk("rd_req_lat", 64'(obs_req_cyc - t_req), 64'd1);
    chk("rd_valid_lat", 64'(obs_valid_first - t_req), 64'd3);
    chk("rd_data", 64'(obs_io_data), 64'hDEADBEEF);

    c0 = obs_req_cnt; e0 = obs_err_cnt;
    do_req(1, 2'h0, 32'h210, 32'h55, 0, 0, 0, 0, 0);
    chk("bad_order_no_req", 64'(obs_req_cnt - c0), 64'd0);
    chk("bad_order_err", 64'(obs_err_cnt - e0), 64'd1);

    do_req(0, 2'h2, 32'h1000, 32'h0, 0, 0, 0, 0, 0);
    chk("unmapped_data", 64'(obs_io_data), 64'd0);
    chk("unmapped_err", 64'(obs_io_err), 64'd1);

    c0 = obs_req_cnt;
    do_req(1, 2'h2, 32'h404, 32'hCAFE0001, 5, 0, 0, 0, 0);
    chk("busy_req_once", 64'(obs_req_cnt - c0), 64'd1);
    chk("busy_req_cycle", 64'(obs_req_cyc - t_req), 64'd6);

    iDEV_REQ = 0;
    do_req(0, 2'h2, 32'h200, 32'h0, 2, 3, 32'h0BADF00D, 0, 1);
    chk("owner_backpressure", 64'(obs_dev_busy), 64'hE);
    chk("owner_data", 64'(obs_io_data), 64'h0BADF00D);

    v0 = obs_valid_cnt;
    do_req(0, 2'h2, 32'h804, 32'h0, 0, 1, 32'h12345678, 3, 0);
    chk("resp_hold_cycles", 64'(obs_valid_cnt - v0), 64'd4);

    bnd[0] = 32'h1FF; bnd[1] = 32'h200; bnd[2] = 32'h9FF; bnd[3] = 32'hA00;
    for (int i = 0; i < 4; i++) begin
      do_req(0, 2'h2, bnd[i], 32'h0, 0, 0, 32'hA5A50000 + 32'(i), 0, 0);
      do_req(1, 2'h2, bnd[i], 32'h77, 0, 0, 0, 0, 0);
    end

    // randomized traffic with concurrent interrupt activity
    irq_auto = 1;
    for (int t = 0; t < 250; t++) begin
      case ($urandom % 6)
        0: a = $urandom_range(0, 32'h1FF);
        1: a = 32'hA00 + ($urandom % 32'h10000);
        2: a = $urandom;
        default: a = 32'h200 + $urandom_range(0, 32'h7FF);
      endcase
      do_req(1'($urandom), ($urandom % 4 == 0) ? 2'($urandom) : 2'h2, a, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), $urandom, $urandom_range(0, 3), 1'($urandom));
      if ($urandom % 4 == 0) begin exp_idle(); cyc(); end
    end
    irq_auto = 0; iIO_INTERRUPT_ACK = 0; iDEV_IRQ_REQ = 0;
    exp_idle(); cyc(); cyc();

    // reset in the middle of a read and a pending interrupt
    do_reset();
    iDEV_IRQ_REQ = 4'b0100; iDEV_IRQ_NUM = 0;
    iIO_REQ = 1; iIO_RW = 0; iIO_ORDER = 2; iIO_ADDR = 32'h400; iIO_DATA = 32'h1234;
    exp_idle(); cyc();
    iIO_REQ = 0; iDEV_BUSY = 0;
    exp_idle(); exp_io_busy = 1; exp_dev_req = 4'h2; exp_dev_chk = 1;
    exp_dev_addr = 0; exp_dev_rw = 0; exp_dev_data = 32'h1234;
    cyc();
    chk("mid_int_pending", 64'(oIO_INTERRUPT_VALID), 64'd1);
    qa = q_ack.size(); v0 = obs_valid_cnt; c1 = obs_req_cnt;
    do_reset();
    exp_idle(); cyc(); cyc(); cyc();
    chk("mid_no_ack", 64'(q_ack.size() - qa), 64'd0);
    chk("mid_no_resp", 64'(obs_valid_cnt - v0), 64'd0);
    chk("mid_no_req", 64'(obs_req_cnt - c1), 64'd0);

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
